// File: rtl/valid_pattern_generator.sv
// Transmit-side valid-lane training source: bursts of 32'hF0F0F0F0 words, length set by mode.
// Optional VALID_GEN_ERR_INJ_EN build adds single-bit error injection on sent words.
module valid_pattern_generator #(
  parameter int unsigned ITER_WORDS   = 128,
  parameter int unsigned CONSEC_WORDS = 4,
  parameter logic [31:0] IDLE_WORD    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable_gen,
  input  logic        i_enable_cons,
  input  logic        i_enable_128,
  input  logic        i_start,
  input  logic        i_inject_err,
  output logic [31:0] o_tvld_l,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_word_cnt
);

  localparam logic [31:0] PATTERN  = 32'hF0F0_F0F0;
  localparam logic [7:0]  L_ITER   = 8'(ITER_WORDS);
  localparam logic [7:0]  L_CONSEC = 8'(CONSEC_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_tvld;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_cnt;
  logic [7:0]  r_len;

  logic [31:0] w_tvld_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_len_nxt;
  logic        w_mode_ok;
  logic [7:0]  w_sel_len;
  logic [31:0] w_send_word;

  assign w_mode_ok = i_enable_cons ^ i_enable_128;
  assign w_sel_len = i_enable_cons ? L_CONSEC : L_ITER;

`ifdef VALID_GEN_ERR_INJ_EN
  assign w_send_word = PATTERN ^ {31'b0, i_inject_err};
`else
  logic w_unused_inject;
  assign w_unused_inject = i_inject_err;
  assign w_send_word     = PATTERN;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every output port is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_tvld_nxt  = IDLE_WORD;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable_gen && i_start && w_mode_ok) begin
          w_state_nxt = S_SEND;
          w_tvld_nxt  = PATTERN;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 8'd1;
          w_len_nxt   = w_sel_len;
        end
      end
      S_SEND: begin
        if (r_cnt >= r_len) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_tvld_nxt = w_send_word;
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!i_enable_gen) begin
      w_state_nxt = S_IDLE;
      w_tvld_nxt  = IDLE_WORD;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tvld <= IDLE_WORD;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_len  <= '0;
    end else begin
      r_tvld <= w_tvld_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_cnt  <= w_cnt_nxt;
      r_len  <= w_len_nxt;
    end
  end

  assign o_tvld_l   = r_tvld;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_word_cnt = r_cnt;

endmodule
